ir_regfile_stage: RTL and testbench

Parametrised instruction-register and register-file front end for the multicycle teaching processor. Latches an instruction through a valid/ready handshake, splits it into opcode/rd/rs1/rs2, reads both source operands from an internal 2-read/1-write register file, and presents the decoded bundle to the execute stage. It generalises the fixed 16-bit IR plus register file: widths and register count are parametrised, write-back data is forwarded, and held operands are refreshed while the stage is stalled.

---
 rtl/proc_pkg.sv | 35 +++
 rtl/regfile_2r1w.sv | 37 +++
 rtl/ir_regfile_stage.sv | 95 +++++++++
 tb/tb_ir_regfile_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the teaching-processor front end: opcodes,
// instruction field positions and a width-generic field extractor.
package proc_pkg;

  localparam int OPC_W_DEF = 4;

  typedef enum logic [OPC_W_DEF-1:0] {
    OPC_NOP = 4'h0,
    OPC_ADD = 4'h1,
    OPC_SUB = 4'h2,
    OPC_AND = 4'h3,
    OPC_OR  = 4'h4,
    OPC_XOR = 4'h5,
    OPC_LD  = 4'h6,
    OPC_ST  = 4'h7
  } opcode_e;

  // Field positions in units of AW bits, counted from the LSB.
  // Layout MSB->LSB: opcode, rd, rs1, rs2.
  localparam int FLD_RS2 = 0;
  localparam int FLD_RS1 = 1;
  localparam int FLD_RD  = 2;
  localparam int FLD_OPC = 3;

  // Pull a w-bit field starting at idx*aw out of an instruction word.
  // Callers truncate the result to the field width; no sign extension.
  function automatic logic [31:0] get_field(input logic [63:0] word,
                                            input int aw, input int idx,
                                            input int w);
    logic [63:0] sh;
    sh = word >> (idx * aw);
    return 32'(sh & ((64'd1 << w) - 64'd1));
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file: combinational reads, synchronous
// write, whole array cleared on reset. Optional hard-wired zero register.
module regfile_2r1w #(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 16,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREGS];

  // Write port; index 0 is dropped when it is the zero register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && !(ZERO_REG && waddr == '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read ports.
  always_comb begin
    rdata1 = (ZERO_REG && raddr1 == '0) ? '0 : mem[raddr1];
    rdata2 = (ZERO_REG && raddr2 == '0) ? '0 : mem[raddr2];
  end

endmodule

// File: rtl/ir_regfile_stage.sv
// Instruction register + register-file read stage. One-entry output
// buffer with write-back forwarding at accept and operand refresh
// while the bundle is stalled.
module ir_regfile_stage
  import proc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 16,
  parameter int OPC_W    = 4,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREGS),
  localparam int INSTR_W = OPC_W + 3 * AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               wb_en,
  input  logic [AW-1:0]      wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [AW-1:0]      out_rd,
  output logic [DATA_W-1:0]  out_rs1_val,
  output logic [DATA_W-1:0]  out_rs2_val
);

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
  } dec_t;

  dec_t              d_in, d_q;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic              accept, stall, wb_live;
  logic              fwd1, fwd2, hit1, hit2;

  // Field split of the incoming word.
  always_comb begin
    d_in.opc = OPC_W'(get_field(64'(instr), AW, FLD_OPC, OPC_W));
    d_in.rd  = AW'(get_field(64'(instr), AW, FLD_RD, AW));
    d_in.rs1 = AW'(get_field(64'(instr), AW, FLD_RS1, AW));
    d_in.rs2 = AW'(get_field(64'(instr), AW, FLD_RS2, AW));
  end

  regfile_2r1w #(.DATA_W(DATA_W), .NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (d_in.rs1),
    .raddr2 (d_in.rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  assign instr_ready = !out_valid || out_ready;
  assign accept      = instr_valid && instr_ready;
  assign stall       = out_valid && !out_ready;

  // A write that actually lands in the file (zero register excluded).
  assign wb_live = wb_en && !(ZERO_REG && wb_addr == '0);
  assign fwd1    = wb_live && wb_addr == d_in.rs1;
  assign fwd2    = wb_live && wb_addr == d_in.rs2;
  assign hit1    = wb_live && wb_addr == d_q.rs1;
  assign hit2    = wb_live && wb_addr == d_q.rs2;

  // Output buffer: load on accept, refresh held operands on stall, drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q         <= '0;
      out_valid   <= 1'b0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
    end else if (accept) begin
      d_q         <= d_in;
      out_valid   <= 1'b1;
      out_rs1_val <= fwd1 ? wb_data : rf_rd1;
      out_rs2_val <= fwd2 ? wb_data : rf_rd2;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (stall && hit1) out_rs1_val <= wb_data;
      if (stall && hit2) out_rs2_val <= wb_data;
    end
  end

  assign out_opcode = d_q.opc;
  assign out_rd     = d_q.rd;

endmodule

// File: tb/tb_ir_regfile_stage.sv
// Bench for ir_regfile_stage: two 16-bit instances (ZERO_REG=1/0) share
// stimulus from a vector table with a scoreboard queue; a third 32-bit,
// 8-register instance covers the parametric and async-reset cases.
module tb_ir_regfile_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for dut0 (ZERO_REG=1) and dut1 (ZERO_REG=0)
  logic        a_iv, a_we, a_ordy;
  logic [15:0] a_ins, a_wd;
  logic [3:0]  a_wa;
  logic        rdy [2];
  logic        ov  [2];
  logic [3:0]  op  [2];
  logic [3:0]  rd  [2];
  logic [15:0] v1  [2];
  logic [15:0] v2  [2];

  ir_regfile_stage #(.DATA_W(16), .NREGS(16), .OPC_W(4), .ZERO_REG(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(a_iv), .instr_ready(rdy[0]),
    .instr(a_ins), .wb_en(a_we), .wb_addr(a_wa), .wb_data(a_wd),
    .out_valid(ov[0]), .out_ready(a_ordy), .out_opcode(op[0]), .out_rd(rd[0]),
    .out_rs1_val(v1[0]), .out_rs2_val(v2[0]));

  ir_regfile_stage #(.DATA_W(16), .NREGS(16), .OPC_W(4), .ZERO_REG(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(a_iv), .instr_ready(rdy[1]),
    .instr(a_ins), .wb_en(a_we), .wb_addr(a_wa), .wb_data(a_wd),
    .out_valid(ov[1]), .out_ready(a_ordy), .out_opcode(op[1]), .out_rd(rd[1]),
    .out_rs1_val(v1[1]), .out_rs2_val(v2[1]));

  // Parametric instance: DATA_W=32, NREGS=8 -> INSTR_W=13
  logic        b_iv, b_we, b_ordy, b_rdy, b_ov;
  logic [12:0] b_ins;
  logic [2:0]  b_wa, b_rd;
  logic [31:0] b_wd, b_v1, b_v2;
  logic [3:0]  b_op;

  ir_regfile_stage #(.DATA_W(32), .NREGS(8), .OPC_W(4), .ZERO_REG(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid(b_iv), .instr_ready(b_rdy),
    .instr(b_ins), .wb_en(b_we), .wb_addr(b_wa), .wb_data(b_wd),
    .out_valid(b_ov), .out_ready(b_ordy), .out_opcode(b_op), .out_rd(b_rd),
    .out_rs1_val(b_v1), .out_rs2_val(b_v2));

  typedef struct {
    logic [3:0]  op, rd;
    logic [15:0] e1, e2;  // expected operands with ZERO_REG=1
    logic [15:0] z1, z2;  // expected operands with ZERO_REG=0
  } bun_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        iv;
    logic [15:0] ins;
    logic        eov;
    bun_t        b;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  bun_t q[$];
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic iv, input logic [15:0] ins, input logic eov,
                              input logic [3:0] eop, input logic [3:0] erd,
                              input logic [15:0] e1, input logic [15:0] e2,
                              input logic [15:0] z1, input logic [15:0] z2);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ins = ins; v.eov = eov;
    v.b.op = eop; v.b.rd = erd; v.b.e1 = e1; v.b.e2 = e2; v.b.z1 = z1; v.b.z2 = z2;
    return v;
  endfunction

  initial begin
    bun_t e;
    //              we   wa    wd        iv   ins       eov  op    rd    e1        e2        z1        z2
    tbl[0]  = mk(1'b1, 4'd3, 16'h1234, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(1'b1, 4'd5, 16'h00FF, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[2]  = mk(1'b0, 4'd0, 16'h0000, 1'b1, 16'h1735, 1'b0, 4'h1, 4'h7, 16'h1234, 16'h00FF, 16'h1234, 16'h00FF);
    tbl[3]  = mk(1'b1, 4'd4, 16'hBEEF, 1'b1, 16'h2144, 1'b1, 4'h2, 4'h1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    tbl[4]  = mk(1'b1, 4'd0, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[5]  = mk(1'b0, 4'd0, 16'h0000, 1'b1, 16'h3100, 1'b0, 4'h3, 4'h1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
    tbl[6]  = mk(1'b1, 4'd0, 16'h1111, 1'b1, 16'h3200, 1'b1, 4'h3, 4'h2, 16'h0000, 16'h0000, 16'h1111, 16'h1111);
    tbl[7]  = mk(1'b0, 4'd0, 16'h0000, 1'b1, 16'h4135, 1'b1, 4'h4, 4'h1, 16'h1234, 16'h00FF, 16'h1234, 16'h00FF);
    tbl[8]  = mk(1'b0, 4'd0, 16'h0000, 1'b1, 16'h5253, 1'b1, 4'h5, 4'h2, 16'h00FF, 16'h1234, 16'h00FF, 16'h1234);
    tbl[9]  = mk(1'b0, 4'd0, 16'h0000, 1'b1, 16'h6344, 1'b1, 4'h6, 4'h3, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
    tbl[10] = mk(1'b0, 4'd0, 16'h0000, 1'b1, 16'h7403, 1'b1, 4'h7, 4'h4, 16'h0000, 16'h1234, 16'h1111, 16'h1234);
    tbl[11] = mk(1'b0, 4'd0, 16'h0000, 1'b1, 16'hF0F0, 1'b1, 4'hF, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h1111);
    tbl[12] = mk(1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b1, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[13] = mk(1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    rst_n = 1'b0;
    a_iv = 0; a_we = 0; a_ordy = 0; a_ins = '0; a_wd = '0; a_wa = '0;
    b_iv = 0; b_we = 0; b_ordy = 0; b_ins = '0; b_wd = '0; b_wa = '0;

    // Reset state, checked while reset is held
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ov%0d", d),  32'(ov[d]),  32'h0);
      chk($sformatf("rst_rdy%0d", d), 32'(rdy[d]), 32'h1);
      chk($sformatf("rst_op%0d", d),  32'(op[d]),  32'h0);
      chk($sformatf("rst_rd%0d", d),  32'(rd[d]),  32'h0);
      chk($sformatf("rst_v1_%0d", d), 32'(v1[d]),  32'h0);
      chk($sformatf("rst_v2_%0d", d), 32'(v2[d]),  32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven: drive row, check valid/ready, pop on consume, push on accept
    for (int i = 0; i < 14; i++) begin
      a_we = tbl[i].we; a_wa = tbl[i].wa; a_wd = tbl[i].wd;
      a_iv = tbl[i].iv; a_ins = tbl[i].ins; a_ordy = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("r%0d_ov%0d", i, d),  32'(ov[d]),  32'(tbl[i].eov));
        chk($sformatf("r%0d_rdy%0d", i, d), 32'(rdy[d]), 32'h1);
      end
      if (tbl[i].eov) begin
        if (q.size() == 0) begin
          chk($sformatf("r%0d_q_underflow", i), 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          for (int d = 0; d < 2; d++) begin
            chk($sformatf("r%0d_op%0d", i, d), 32'(op[d]), 32'(e.op));
            chk($sformatf("r%0d_rd%0d", i, d), 32'(rd[d]), 32'(e.rd));
          end
          chk($sformatf("r%0d_v1_z1", i), 32'(v1[0]), 32'(e.e1));
          chk($sformatf("r%0d_v2_z1", i), 32'(v2[0]), 32'(e.e2));
          chk($sformatf("r%0d_v1_z0", i), 32'(v1[1]), 32'(e.z1));
          chk($sformatf("r%0d_v2_z0", i), 32'(v2[1]), 32'(e.z2));
        end
      end
      if (tbl[i].iv) q.push_back(tbl[i].b);
      @(posedge clk); #1;
    end
    chk("q_empty", 32'(q.size()), 32'h0);

    // Stall with held refresh; instr must not be sampled while stalled
    a_we = 0; a_iv = 1; a_ins = 16'h8935; a_ordy = 0;
    #1;
    for (int d = 0; d < 2; d++) chk($sformatf("s1_rdy%0d", d), 32'(rdy[d]), 32'h1);
    @(posedge clk); #1;
    a_we = 1; a_wa = 4'd3; a_wd = 16'hAAAA; a_ins = 16'h9999;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s2_ov%0d", d),  32'(ov[d]),  32'h1);
      chk($sformatf("s2_rdy%0d", d), 32'(rdy[d]), 32'h0);
      chk($sformatf("s2_v1_%0d", d), 32'(v1[d]),  32'h1234);
      chk($sformatf("s2_v2_%0d", d), 32'(v2[d]),  32'h00FF);
    end
    @(posedge clk); #1;
    a_wa = 4'd5; a_wd = 16'h5555;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s3_v1_%0d", d), 32'(v1[d]),  32'hAAAA);
      chk($sformatf("s3_v2_%0d", d), 32'(v2[d]),  32'h00FF);
      chk($sformatf("s3_op%0d", d),  32'(op[d]),  32'h8);
      chk($sformatf("s3_rd%0d", d),  32'(rd[d]),  32'h9);
      chk($sformatf("s3_rdy%0d", d), 32'(rdy[d]), 32'h0);
    end
    @(posedge clk); #1;
    a_we = 0; a_iv = 0; a_ordy = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s4_v1_%0d", d), 32'(v1[d]),  32'hAAAA);
      chk($sformatf("s4_v2_%0d", d), 32'(v2[d]),  32'h5555);
      chk($sformatf("s4_ov%0d", d),  32'(ov[d]),  32'h1);
      chk($sformatf("s4_rdy%0d", d), 32'(rdy[d]), 32'h1);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("s5_ov%0d", d),  32'(ov[d]), 32'h0);
      chk($sformatf("s5_v1_%0d", d), 32'(v1[d]), 32'hAAAA);
      chk($sformatf("s5_op%0d", d),  32'(op[d]), 32'h8);
    end

    // Parametric instance: load R2/R6, accept op A rd 5 rs1 2 rs2 6
    b_we = 1; b_wa = 3'd2; b_wd = 32'hDEADBEEF;
    @(posedge clk); #1;
    b_wa = 3'd6; b_wd = 32'h01234567;
    @(posedge clk); #1;
    b_we = 0; b_iv = 1; b_ins = 13'h1556; b_ordy = 0;
    @(posedge clk); #1;
    b_iv = 0;
    chk("p_ov",  32'(b_ov),  32'h1);
    chk("p_op",  32'(b_op),  32'hA);
    chk("p_rd",  32'(b_rd),  32'h5);
    chk("p_v1",  b_v1,       32'hDEADBEEF);
    chk("p_v2",  b_v2,       32'h01234567);
    chk("p_rdy", 32'(b_rdy), 32'h0);
    // Asynchronous reset mid-stall, between clock edges
    #2 rst_n = 1'b0;
    #1;
    chk("par_ov",  32'(b_ov),  32'h0);
    chk("par_op",  32'(b_op),  32'h0);
    chk("par_v1",  b_v1,       32'h0);
    chk("par_rdy", 32'(b_rdy), 32'h1);
    #2 rst_n = 1'b1;
    b_iv = 1; b_ordy = 1;
    @(posedge clk); #1;
    b_iv = 0;
    chk("pp_ov", 32'(b_ov), 32'h1);
    chk("pp_op", 32'(b_op), 32'hA);
    chk("pp_v1", b_v1,      32'h0);
    chk("pp_v2", b_v2,      32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
